// File: rtl/key_filter_multi.sv
// key_filter_multi: multi-channel push-button conditioner.
// Each raw key is synchronised (2 FF), debounced with a programmable stable
// time, and turned into a clean level plus one-cycle press / release /
// long-press / auto-repeat pulses. Channels are fully independent.
//
// Ports:
//   sys_clk      system clock
//   sys_rst_n    asynchronous active-low reset
//   key          raw asynchronous key levels, bit i = channel i
//   key_value    debounced level per channel (same polarity as key)
//   key_press    1-cycle pulse on debounced idle->pressed
//   key_release  1-cycle pulse on debounced pressed->idle
//   key_long     1-cycle pulse LONG_CYCLES after press while held
//   key_repeat   1-cycle pulse every REPEAT_CYCLES after key_long while held

// One channel: synchroniser -> debounce counter -> hold FSM.
module key_filter_chan #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key,
  output logic key_value,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_repeat
);
  localparam logic IDLE_LVL = ACTIVE_LOW;
  localparam int   DBW      = $clog2(DEBOUNCE_CYCLES);
  localparam int   HMAX     = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int   HW       = $clog2(HMAX + 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]  LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0]  REP_LAST  = HW'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_LONG} state_t;

  logic [1:0]     sync;
  logic [DBW-1:0] db_cnt;
  logic           accept, press_acc, rel_acc;
  state_t         state, state_nxt;
  logic [HW-1:0]  hold_cnt, cnt_nxt;
  logic           long_nxt, rep_nxt;

  // sync[1] is the synchronised level; acceptance happens on the
  // DEBOUNCE_CYCLES-th consecutive cycle it differs from key_value.
  assign accept    = (sync[1] != key_value) && (db_cnt == DB_LAST);
  assign press_acc = accept && (sync[1] != IDLE_LVL);
  assign rel_acc   = accept && (sync[1] == IDLE_LVL);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync        <= {2{IDLE_LVL}};
      db_cnt      <= '0;
      key_value   <= IDLE_LVL;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      sync        <= {sync[0], key};
      key_press   <= press_acc;
      key_release <= rel_acc;
      if (sync[1] == key_value) begin
        db_cnt <= '0;
      end else if (accept) begin
        key_value <= sync[1];
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      key_long   <= 1'b0;
      key_repeat <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= cnt_nxt;
      key_long   <= long_nxt;
      key_repeat <= rep_nxt;
    end
  end

  // Release is checked first so it suppresses a long/repeat expiring the
  // same cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = hold_cnt;
    long_nxt  = 1'b0;
    rep_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (press_acc) begin
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
        end
      end
      ST_HELD: begin
        if (rel_acc) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (hold_cnt == LONG_LAST) begin
          long_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_LONG;
        end else begin
          cnt_nxt = hold_cnt + 1'b1;
        end
      end
      ST_LONG: begin
        if (rel_acc) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (REPEAT_CYCLES != 0) begin
          if (hold_cnt == REP_LAST) begin
            rep_nxt = 1'b1;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = hold_cnt + 1'b1;
          end
        end else begin
          cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end
endmodule

module key_filter_multi #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_value,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat
);
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    key_filter_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_chan (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .key        (key[g]),
      .key_value  (key_value[g]),
      .key_press  (key_press[g]),
      .key_release(key_release[g]),
      .key_long   (key_long[g]),
      .key_repeat (key_repeat[g])
    );
  end
endmodule
